// File: rtl/hv_encode_ctrl.sv
// Position-hypervector encode controller.
// Holds the pixel scalar bank and sequences the VDC/T-flop datapath. Each
// datapath output slice is majority-bundled into one bit of the image
// hypervector, which is emitted serially.
module hv_encode_ctrl #(
    parameter int unsigned NPIX   = 144,
    parameter int unsigned SW     = 10,
    parameter int unsigned DIM    = 1024,
    parameter int unsigned DP_LAT = 1,
    localparam int unsigned IW    = $clog2(DIM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pix_we,
    input  logic [7:0]           pix_addr,
    input  logic [SW-1:0]        pix_data,
    output logic [NPIX*SW-1:0]   scalar_flat,
    output logic                 dp_reset,
    input  logic [NPIX-1:0]      dp_in,
    output logic                 hv_bit,
    output logic                 hv_valid,
    output logic [IW-1:0]        hv_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWait,
        StRun,
        StFlush
    } state_e;

    localparam int unsigned HALF = NPIX / 2;
    localparam bit NPIX_EVEN = (NPIX % 2) == 0;

    state_e            state_q;
    logic [IW-1:0]     k_q;
    logic [3:0]        lat_q;
    logic [NPIX-1:0]   sample_q;
    logic              valid_q;
    logic [IW-1:0]     idx_q;
    logic              done_q;
    logic              dp_reset_q;
    logic [SW-1:0]     bank_q [NPIX];
    logic [7:0]        pop_cnt;

    // Scalar bank: writes only while idle and only for in-range addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NPIX; i++) begin
                bank_q[i] <= '0;
            end
        end else if (pix_we && (state_q == StIdle) && (32'(pix_addr) < NPIX)) begin
            bank_q[pix_addr] <= pix_data;
        end
    end

    // Flatten the bank onto the datapath bus.
    always_comb begin
        scalar_flat = '0;
        for (int unsigned i = 0; i < NPIX; i++) begin
            scalar_flat[i*SW +: SW] = bank_q[i];
        end
    end

    // Sequencer: state, counters, sample register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= '0;
            lat_q      <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            dp_reset_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if ((state_q != StIdle) && abort) begin
                // Discard the partial run; the bank is left untouched.
                state_q    <= StIdle;
                k_q        <= '0;
                lat_q      <= '0;
                dp_reset_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        dp_reset_q <= 1'b1;
                        k_q        <= '0;
                        lat_q      <= '0;
                        if (start && !abort) begin
                            state_q <= StClear;
                        end
                    end
                    StClear: begin
                        state_q    <= StWait;
                        dp_reset_q <= 1'b0;
                        lat_q      <= '0;
                    end
                    StWait: begin
                        if (lat_q == 4'(DP_LAT - 1)) begin
                            state_q <= StRun;
                            lat_q   <= '0;
                        end else begin
                            lat_q <= lat_q + 4'd1;
                        end
                    end
                    StRun: begin
                        sample_q <= dp_in;
                        idx_q    <= k_q;
                        valid_q  <= 1'b1;
                        done_q   <= (k_q == IW'(DIM - 1));
                        if (k_q == IW'(DIM - 1)) begin
                            state_q    <= StFlush;
                            k_q        <= '0;
                            dp_reset_q <= 1'b1;
                        end else begin
                            k_q <= k_q + IW'(1);
                        end
                    end
                    StFlush: begin
                        state_q    <= StIdle;
                        dp_reset_q <= 1'b1;
                    end
                    default: begin
                        state_q    <= StIdle;
                        dp_reset_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Majority vote over the registered slice; ties alternate on the index LSB.
    always_comb begin
        pop_cnt = '0;
        for (int unsigned i = 0; i < NPIX; i++) begin
            pop_cnt = pop_cnt + {7'd0, sample_q[i]};
        end
        if (pop_cnt > 8'(HALF)) begin
            hv_bit = 1'b1;
        end else if ((pop_cnt == 8'(HALF)) && NPIX_EVEN) begin
            hv_bit = idx_q[0];
        end else begin
            hv_bit = 1'b0;
        end
    end

    assign hv_valid = valid_q;
    assign hv_idx   = idx_q;
    assign done     = done_q;
    assign dp_reset = dp_reset_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_hv_encode_ctrl.sv
// Self-checking bench for hv_encode_ctrl: scoreboard of expected hypervector
// bits filled as dp_in is driven and drained as hv_valid appears.
module tb_hv_encode_ctrl;

    localparam int NPIX   = 144;
    localparam int SW     = 10;
    localparam int DIM    = 1024;
    localparam int DP_LAT = 1;
    localparam int IW     = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic               pix_we;
    logic [7:0]         pix_addr;
    logic [SW-1:0]      pix_data;
    logic [NPIX*SW-1:0] scalar_flat;
    logic               dp_reset;
    logic [NPIX-1:0]    dp_in;
    logic               hv_bit;
    logic               hv_valid;
    logic [IW-1:0]      hv_idx;
    logic               busy;
    logic               done;

    hv_encode_ctrl #(
        .NPIX   (NPIX),
        .SW     (SW),
        .DIM    (DIM),
        .DP_LAT (DP_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pix_we      (pix_we),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .scalar_flat (scalar_flat),
        .dp_reset    (dp_reset),
        .dp_in       (dp_in),
        .hv_bit      (hv_bit),
        .hv_valid    (hv_valid),
        .hv_idx      (hv_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    int exp_idx_q[$];
    bit exp_bit_q[$];
    logic [NPIX*SW-1:0] exp_flat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt(input logic [NPIX-1:0] v);
        int c = 0;
        for (int i = 0; i < NPIX; i++) if (v[i]) c++;
        return c;
    endfunction

    // Reference majority: above half -> 1, below -> 0, exact half -> k odd.
    function automatic bit maj(input logic [NPIX-1:0] v, input int k);
        int c = popcnt(v);
        if (2 * c > NPIX) return 1'b1;
        if (2 * c < NPIX) return 1'b0;
        return (k % 2) == 1;
    endfunction

    function automatic logic [NPIX-1:0] rand_vec();
        logic [NPIX-1:0] v;
        for (int i = 0; i < NPIX; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [NPIX-1:0] vec_pc(input int pc);
        logic [NPIX-1:0] v = '0;
        int r = $urandom_range(0, NPIX - 1);
        for (int i = 0; i < pc; i++) v[i] = 1'b1;
        if (r != 0) v = (v << r) | (v >> (NPIX - r));
        return v;
    endfunction

    // Scoreboard drain.
    always @(negedge clk) begin : mon
        int ei;
        bit eb;
        if (mon_en && !reset) begin
            if (done) done_cnt++;
            if (hv_valid) begin
                if (exp_idx_q.size() == 0) begin
                    check("sb_underflow", exp_idx_q.size(), 1);
                end else begin
                    ei = exp_idx_q.pop_front();
                    eb = exp_bit_q.pop_front();
                    check("hv_idx", hv_idx, ei);
                    check("hv_bit", hv_bit, eb);
                    check("done_at_idx", done, ei == DIM - 1);
                end
            end else if (done) begin
                check("done_no_valid", hv_valid, 1);
            end
        end
    end

    task automatic bank_write(input int addr, input logic [SW-1:0] data);
        pix_we = 1'b1;
        pix_addr = 8'(addr);
        pix_data = data;
        @(posedge clk); #1;
        pix_we = 1'b0;
        if (addr < NPIX) exp_flat[addr*SW +: SW] = data;
    endtask

    // One encode run starting in the current (idle) cycle; negative k disables an option.
    task automatic do_run(input int mode, input int abort_k, input int sb_k, input int wb_k,
                          input bit we_start);
        int d0 = done_cnt;
        int gaps = 0;
        int pcs [4] = '{73, 71, 72, 72};
        logic [NPIX-1:0] v;
        start = 1'b1;
        if (we_start) begin
            pix_we = 1'b1;
            pix_addr = 8'd5;
            pix_data = 10'h2AA;
            exp_flat[5*SW +: SW] = 10'h2AA;
        end
        @(posedge clk); #1;
        start = 1'b0;
        pix_we = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_dprst", dp_reset, 1);
        if (we_start) check("we_with_start", scalar_flat[59:50], 10'h2AA);
        @(posedge clk); #1;
        check("wait_dprst", dp_reset, 0);
        check("wait_valid", hv_valid, 0);
        @(posedge clk); #1;
        for (int k = 0; k < DIM; k++) begin
            if (k > 0) begin
                if (!(hv_valid && hv_idx == IW'(k - 1))) gaps++;
            end else if (hv_valid) begin
                gaps++;
            end
            if (dp_reset || !busy) gaps++;
            if (k == 1) check("first_valid", {hv_valid, hv_idx}, {1'b1, 10'd0});
            start = (k == sb_k);
            if (k == wb_k) begin
                pix_we = 1'b1;
                pix_addr = 8'd7;
                pix_data = 10'h0F0;
            end else begin
                pix_we = 1'b0;
            end
            if (mode == 1 && k < 4) v = vec_pc(pcs[k]);
            else v = rand_vec();
            dp_in = v;
            if (k == abort_k) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                start = 1'b0;
                pix_we = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_dprst", dp_reset, 1);
                check("abort_valid", hv_valid, 0);
                repeat (3) @(posedge clk);
                #1;
                check("abort_no_done", done_cnt, d0);
                check("abort_sb_empty", exp_idx_q.size(), 0);
                return;
            end
            exp_idx_q.push_back(k);
            exp_bit_q.push_back(maj(v, k));
            @(posedge clk); #1;
        end
        start = 1'b0;
        pix_we = 1'b0;
        check("run_gaps", gaps, 0);
        check("flush_valid", hv_valid, 1);
        check("flush_idx", hv_idx, DIM - 1);
        check("flush_done", done, 1);
        check("flush_busy", busy, 1);
        check("flush_dprst", dp_reset, 1);
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_valid", hv_valid, 0);
        check("idle_done", done, 0);
        check("idle_dprst", dp_reset, 1);
        check("done_count", done_cnt, d0 + 1);
        check("sb_empty", exp_idx_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pix_we = 1'b0;
        pix_addr = '0;
        pix_data = '0;
        dp_in = '0;
        exp_flat = '0;
        #3;
        check("rst_dprst", dp_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", hv_valid, 0);
        check("rst_flat", scalar_flat == '0, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        bank_write(0, 10'h3FF);
        bank_write(143, 10'h155);
        bank_write(200, 10'h001);
        check("flat_addr0", scalar_flat[9:0], 10'h3FF);
        check("flat_addr143", scalar_flat[1439:1430], 10'h155);
        check("flat_all", scalar_flat == exp_flat, 1);

        mon_en = 1'b1;
        // Threshold/tie prefix, start while busy, write while busy.
        do_run(1, -1, 10, 20, 1'b0);
        check("busy_write", scalar_flat[79:70], 0);
        check("flat_after_run", scalar_flat == exp_flat, 1);

        repeat (2) @(posedge clk);
        #1;
        do_run(0, 500, -1, -1, 1'b0);
        check("flat_after_abort", scalar_flat == exp_flat, 1);

        // Restart after abort with a same-cycle write, then back-to-back.
        do_run(0, -1, -1, -1, 1'b1);
        do_run(0, -1, -1, -1, 1'b0);
        check("flat_final", scalar_flat == exp_flat, 1);

        // Asynchronous reset in the middle of a run.
        mon_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_dprst", dp_reset, 1);
        check("midrst_valid", hv_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_flat", scalar_flat == '0, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hv_encode_ctrl.md
Name: hv_encode_ctrl

Overview:
- Sequencer and bundler for the 144-pixel position-hypervector datapath (per-pixel 10-bit VDC comparator, T-flop and XOR stage).
- Holds the pixel scalar bank and drives it to the datapath as a flat bus.
- Clears the VDC generators, then runs the datapath for DIM cycles.
- Majority-bundles each 144-bit output slice into one hypervector bit, emitting a DIM-bit image hypervector serially with a handshake-free valid strobe.

Parameters:
- NPIX, 144, pixel count and datapath width.
- SW, 10, scalar width; must match the VDC width.
- DIM, 1024, hypervector dimension, equal to cycles in RUN.
- DP_LAT, 1, cycles from dp_reset deassertion to the first valid dp_in sample; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin an encode; sampled only in IDLE.
- abort  in  1  synchronous cancel.
- pix_we  in  1  scalar bank write enable.
- pix_addr  in  8  pixel index.
- pix_data  in  SW  scalar value.
- scalar_flat  out  NPIX*SW  bank contents; pixel i occupies bits [i*SW +: SW].
- dp_reset  out  1  reset to the VDC/T-flop datapath, active-high.
- dp_in  in  NPIX  datapath output slice (out_p).
- hv_bit  out  1  bundled hypervector bit.
- hv_valid  out  1  hv_bit/hv_idx valid this cycle.
- hv_idx  out  clog2(DIM)  dimension index of hv_bit.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on the final hv_valid.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; all 144 bank entries clear to 0.
  - dp_reset=1; hv_bit, hv_valid, hv_idx, busy and done all 0.
  - The counter and sample register clear.
- Bank writes
  - Accepted only when busy=0 and pix_addr<NPIX; otherwise silently ignored.
  - The write lands at the clock edge. scalar_flat is the register contents, with no combinational path from pix_data.
- FSM states: IDLE, CLEAR, WAIT, RUN, FLUSH.
  - IDLE: dp_reset=1. start=1 moves to CLEAR. A pix_we in the same cycle as start still lands and is used by the run.
  - CLEAR: one cycle with dp_reset=1, then WAIT.
  - WAIT: DP_LAT cycles with dp_reset=0, then RUN.
  - RUN: DIM cycles with dp_reset=0. Each cycle registers dp_in into the sample register and increments the sample index k from 0 to DIM-1. After k=DIM-1, go to FLUSH.
  - FLUSH: one cycle, emits the last bit, then IDLE with dp_reset=1 on the following cycle.
- start while busy=1 is ignored.
- Bundling is one cycle after each sample.
  - hv_valid=1 and hv_idx=k.
  - hv_bit = 1 if popcount(sample) > NPIX/2.
  - hv_bit = 0 if popcount(sample) < NPIX/2.
  - If popcount(sample) == NPIX/2 (tie, NPIX even), hv_bit = k[0].
  - The popcount is 8 bits wide, which suffices for NPIX ≤ 255.
- Timing for DP_LAT=1, with start sampled at edge t:
  - CLEAR at t+1, WAIT at t+2, RUN from t+3 to t+2+DIM.
  - hv_valid from t+4 to t+3+DIM, contiguous with no gaps.
  - done=1 only at t+3+DIM, together with hv_idx=DIM-1.
  - busy=1 from t+1 to t+3+DIM.
- In general, total latency from start to done is DIM+2+DP_LAT cycles.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with dp_reset=1 and hv_valid=0.
  - done is never asserted for the aborted run; the partial sequence is discarded.
  - The bank is preserved.
  - If abort and start are both high in IDLE, start is ignored.
- Reset mid-run: immediate return to the reset state; no done is produced.
- hv_idx wraps only by restarting: each run begins at 0 and never exceeds DIM-1.
- Back-to-back: start asserted in the cycle right after done is accepted, because the FSM is in IDLE then.

Test Plan:
- Reset values: assert reset mid-cycle with no clock → dp_reset=1, busy=0, hv_valid=0, scalar_flat=0 immediately.
- Bank write and readback:
  - Write addr 0=10'h3FF, addr 143=10'h155, addr 200=10'h001 → scalar_flat[9:0]=3FF and [1439:1430]=155; no other bits change.
  - A write while busy=1 is ignored.
- Full run, DIM=1024, DP_LAT=1, dp_in driven from a model:
  - Start at t → first hv_valid at t+4 with hv_idx=0.
  - 1024 contiguous valids; done coincident with hv_idx=1023.
  - busy falls at t+4+DIM.
  - dp_reset is low exactly during WAIT/RUN.
- Threshold and tie, dp_in with popcount 73, 71, 72, 72 at k=0..3 → hv_bit 1, 0, 0, 1.
- Abort at RUN cycle k=500:
  - Next cycle busy=0 and dp_reset=1; no done.
  - A restart yields hv_idx starting at 0.
  - Bank contents are unchanged.
- Collisions:
  - start while busy → no effect on the sequence.
  - start and pix_we (addr 5, 10'h2AA) in the same IDLE cycle → scalar_flat[59:50]=2AA before CLEAR ends.
  - start the cycle after done → a new run with the same timing as the full-run test.
